// File: rtl/idex_hazard_if.sv
// Handshake/control bundle between the pipeline stage registers and idex_hazard_ctrl.
// Latency: wires only. The master side is the pipeline and drives the ID/EX view and the stall sources.
// Backpressure: none of its own. The slave side (controller) returns enables, flush and bubble.
// The stall_cnt and flush_cnt statistics outputs exist only when HAZARD_STATS_EN is defined.
interface idex_hazard_if #(
    parameter int OP_W  = 5,
    parameter int REG_W = 9
);
    logic [OP_W-1:0]  id_opcode;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic [OP_W-1:0]  ex_opcode;
    logic [REG_W-1:0] ex_rd;
    logic             branch_taken;
    logic             mem_busy;
    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_bubble;
    logic [1:0]       state;
`ifdef HAZARD_STATS_EN
    logic [15:0]      stall_cnt;
    logic [15:0]      flush_cnt;

    modport master (
        output id_opcode, id_rs, id_rt, ex_opcode, ex_rd, branch_taken, mem_busy,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, state,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_opcode, id_rs, id_rt, ex_opcode, ex_rd, branch_taken, mem_busy,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, state,
        output stall_cnt, flush_cnt
    );
`else
    modport master (
        output id_opcode, id_rs, id_rt, ex_opcode, ex_rd, branch_taken, mem_busy,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, state
    );

    modport slave (
        input  id_opcode, id_rs, id_rt, ex_opcode, ex_rd, branch_taken, mem_busy,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, state
    );
`endif
endinterface

// File: rtl/idex_hazard_ctrl.sv
// Pipeline sequencer for PC, IF/ID and ID/EX: handles load-use, multi-cycle EX, branch flush and memory stalls.
// Latency: all controls are combinational from state/cnt/inputs. The stage registers sample them at the next edge.
// Backpressure: mem_busy freezes everything and holds the sequence. Optional HAZARD_STATS_EN adds saturating counters.
module idex_hazard_ctrl #(
    parameter int              OP_W         = 5,
    parameter int              REG_W        = 9,
    parameter logic [OP_W-1:0] LOAD_OP      = 5'b01000,
    parameter logic [OP_W-1:0] MULTI_OP     = 5'b01100,
    parameter int              MULTI_CYCLES = 4,
    parameter int              BRANCH_SLOTS = 2
) (
    input  logic              clk,
    input  logic              rst,
    idex_hazard_if.slave      hif
);

    // The counter only ever needs to hold the larger of the two reload values.
    localparam int CNT_MAX_MC = MULTI_CYCLES - 2;
    localparam int CNT_MAX_BR = (BRANCH_SLOTS >= 2) ? (BRANCH_SLOTS - 2) : 0;
    localparam int CNT_MAX    = (CNT_MAX_MC > CNT_MAX_BR) ? CNT_MAX_MC : CNT_MAX_BR;
    localparam int CNT_W      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(CNT_MAX_MC);
    localparam logic [CNT_W-1:0] BR_LOAD = CNT_W'(CNT_MAX_BR);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MC_BUSY = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic pc_en_c;
    logic ifid_en_c;
    logic ifid_flush_c;
    logic idex_en_c;
    logic idex_bubble_c;
    logic load_use;

    // id_opcode is part of the ID view but does not influence sequencing.
    logic unused_id_opcode;
    assign unused_id_opcode = ^hif.id_opcode;

    // Load-use hazard: a load in EX whose destination feeds an ID source; r0 is never a hazard.
    assign load_use = (hif.ex_opcode == LOAD_OP) &&
                      (hif.ex_rd != '0) &&
                      ((hif.ex_rd == hif.id_rs) || (hif.ex_rd == hif.id_rt));

    // State and residency counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode: rst, then mem_busy, then the current-state rules.
    always_comb begin
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        ifid_flush_c  = 1'b0;
        idex_en_c     = 1'b1;
        idex_bubble_c = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;

        if (rst) begin
            // Front end keeps moving but loads NOPs so nothing stale survives reset.
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
            state_d       = RUN;
            cnt_d         = '0;
        end else if (hif.mem_busy) begin
            // Whole front end frozen; sequence position is preserved.
            pc_en_c   = 1'b0;
            ifid_en_c = 1'b0;
            idex_en_c = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hif.branch_taken) begin
                        // Wrong-path instructions in IF/ID and ID are squashed.
                        ifid_flush_c  = 1'b1;
                        idex_bubble_c = 1'b1;
                        if (BRANCH_SLOTS >= 2) begin
                            cnt_d   = BR_LOAD;
                            state_d = FLUSH;
                        end
                    end else if (hif.ex_opcode == MULTI_OP) begin
                        // First frozen cycle of the multi-cycle op; the rest are counted in MC_BUSY.
                        pc_en_c   = 1'b0;
                        ifid_en_c = 1'b0;
                        idex_en_c = 1'b0;
                        cnt_d     = MC_LOAD;
                        state_d   = MC_BUSY;
                    end else if (load_use) begin
                        // Hold the consumer in ID and push a bubble into EX; the load moves on to MEM.
                        pc_en_c       = 1'b0;
                        ifid_en_c     = 1'b0;
                        idex_bubble_c = 1'b1;
                    end
                end

                MC_BUSY: begin
                    if (cnt_q != '0) begin
                        pc_en_c   = 1'b0;
                        ifid_en_c = 1'b0;
                        idex_en_c = 1'b0;
                        cnt_d     = cnt_q - 1'b1;
                    end else begin
                        // Release cycle: the op leaves EX as the next instruction enters.
                        state_d = RUN;
                    end
                end

                FLUSH: begin
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end

                default: begin
                    // Encoding 3 is never entered; recover to RUN if it ever appears.
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign hif.pc_en       = pc_en_c;
    assign hif.ifid_en     = ifid_en_c;
    assign hif.ifid_flush  = ifid_flush_c;
    assign hif.idex_en     = idex_en_c;
    assign hif.idex_bubble = idex_bubble_c;
    assign hif.state       = state_q;

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    // Saturating counts of PC-stall cycles and IF/ID flush cycles outside reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (!pc_en_c && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
            if (ifid_flush_c && (flush_q != 16'hFFFF)) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign hif.stall_cnt = stall_q;
    assign hif.flush_cnt = flush_q;
`endif

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Self-checking bench for idex_hazard_ctrl: directed scenarios followed by random traffic.
// Expected values come from a schedule-queue model: each hazard event enqueues the per-cycle actions it implies.
// mem_busy pauses the schedule, and reset discards it.
module tb_idex_hazard_ctrl;

    localparam int             OP_W         = 5;
    localparam int             REG_W        = 9;
    localparam logic [4:0]     LOAD_OP      = 5'b01000;
    localparam logic [4:0]     MULTI_OP     = 5'b01100;
    localparam int             MULTI_CYCLES = 4;
    localparam int             BRANCH_SLOTS = 2;

    localparam int A_FREEZE  = 1;
    localparam int A_RELEASE = 2;
    localparam int A_FLUSH   = 3;

    logic clk = 1'b0;
    logic rst;

    idex_hazard_if #(.OP_W(OP_W), .REG_W(REG_W)) hif ();

    idex_hazard_ctrl #(
        .OP_W(OP_W), .REG_W(REG_W), .LOAD_OP(LOAD_OP), .MULTI_OP(MULTI_OP),
        .MULTI_CYCLES(MULTI_CYCLES), .BRANCH_SLOTS(BRANCH_SLOTS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hif(hif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int sched[$];
    bit state_known = 1'b0;
    int exp_stall = 0;
    int exp_flush = 0;

    // One cycle: drive inputs, predict, compare at the falling edge, then advance to the next rising edge.
    task automatic step(input bit r, input bit bt, input bit mb,
                        input logic [4:0] exop, input logic [8:0] rs,
                        input logic [8:0] rt, input logic [8:0] rd,
                        input string tag);
        logic [4:0] exp_ctl;
        logic [4:0] obs_ctl;
        logic [1:0] exp_state;
        bit pc, ie, fl, xe, bb, lu;
        int act;
        rst              = r;
        hif.branch_taken = bt;
        hif.mem_busy     = mb;
        hif.ex_opcode    = exop;
        hif.id_rs        = rs;
        hif.id_rt        = rt;
        hif.ex_rd        = rd;
        hif.id_opcode    = 5'($urandom_range(0, 31));
        @(negedge clk);

        pc = 1; ie = 1; fl = 0; xe = 1; bb = 0;
        if (sched.size() == 0)          exp_state = 2'd0;
        else if (sched[0] == A_FLUSH)   exp_state = 2'd2;
        else                            exp_state = 2'd1;

        if (r) begin
            fl = 1; bb = 1;
        end else if (mb) begin
            pc = 0; ie = 0; xe = 0;
        end else if (sched.size() != 0) begin
            act = sched.pop_front();
            if (act == A_FREEZE) begin
                pc = 0; ie = 0; xe = 0;
            end else if (act == A_FLUSH) begin
                fl = 1; bb = 1;
            end
        end else begin
            lu = (exop == LOAD_OP) && (rd != 0) && (rd == rs || rd == rt);
            if (bt) begin
                fl = 1; bb = 1;
                for (int i = 0; i < BRANCH_SLOTS - 1; i++) sched.push_back(A_FLUSH);
            end else if (exop == MULTI_OP) begin
                pc = 0; ie = 0; xe = 0;
                for (int i = 0; i < MULTI_CYCLES - 2; i++) sched.push_back(A_FREEZE);
                sched.push_back(A_RELEASE);
            end else if (lu) begin
                pc = 0; ie = 0; bb = 1;
            end
        end

        exp_ctl = {pc, ie, fl, xe, bb};
        obs_ctl = {hif.pc_en, hif.ifid_en, hif.ifid_flush, hif.idex_en, hif.idex_bubble};
        checks++;
        assert (obs_ctl === exp_ctl) else begin
            errors++;
            $error("FAIL %s ctl{pc,ifid,flush,idex,bubble} observed=%b expected=%b", tag, obs_ctl, exp_ctl);
        end
        if (state_known) begin
            checks++;
            assert (hif.state === exp_state) else begin
                errors++;
                $error("FAIL %s state observed=%0d expected=%0d", tag, hif.state, exp_state);
            end
        end
`ifdef HAZARD_STATS_EN
        if (state_known) begin
            checks++;
            assert (hif.stall_cnt === 16'(exp_stall)) else begin
                errors++;
                $error("FAIL %s stall_cnt observed=%h expected=%h", tag, hif.stall_cnt, 16'(exp_stall));
            end
            checks++;
            assert (hif.flush_cnt === 16'(exp_flush)) else begin
                errors++;
                $error("FAIL %s flush_cnt observed=%h expected=%h", tag, hif.flush_cnt, 16'(exp_flush));
            end
        end
`endif
        if (r) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (!pc && exp_stall < 65535) exp_stall++;
            if (fl && exp_flush < 65535) exp_flush++;
        end

        if (r) begin
            sched.delete();
            state_known = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        step(0, 0, 0, 5'd0, 9'd0, 9'd0, 9'd0, tag);
    endtask

    initial begin
        logic [4:0] exop;
        // Reset for two cycles, then a quiet cycle.
        step(1, 0, 0, 5'd0, 9'd0, 9'd0, 9'd0, "rst0");
        step(1, 0, 0, 5'd0, 9'd0, 9'd0, 9'd0, "rst1");
        idle("post_rst");

        // Load-use on Rs, then the bubble in EX; then a load to r0 must not stall.
        step(0, 0, 0, LOAD_OP, 9'd5, 9'd7, 9'd5, "lu_rs");
        idle("lu_after");
        step(0, 0, 0, LOAD_OP, 9'd3, 9'd6, 9'd6, "lu_rt");
        idle("lu_rt_after");
        step(0, 0, 0, LOAD_OP, 9'd0, 9'd0, 9'd0, "lu_r0");
        step(0, 0, 0, LOAD_OP, 9'd4, 9'd4, 9'd2, "lu_nomatch");

        // Multi-cycle op resident in EX for MULTI_CYCLES cycles.
        for (int i = 0; i < MULTI_CYCLES; i++) step(0, 0, 0, MULTI_OP, 9'd1, 9'd2, 9'd3, "mc");
        idle("mc_after");

        // Taken branch: flush for BRANCH_SLOTS cycles.
        step(0, 1, 0, 5'd0, 9'd0, 9'd0, 9'd0, "br");
        step(0, 1, 0, 5'd0, 9'd0, 9'd0, 9'd0, "br_flush_ignored");
        idle("br_after");

        // mem_busy while MC_BUSY with cnt=1.
        step(0, 0, 0, MULTI_OP, 9'd0, 9'd0, 9'd0, "mcb_start");
        step(0, 0, 0, MULTI_OP, 9'd0, 9'd0, 9'd0, "mcb_cnt2");
        for (int i = 0; i < 3; i++) step(0, 1, 1, MULTI_OP, 9'd0, 9'd0, 9'd0, "mcb_busy");
        step(0, 0, 0, MULTI_OP, 9'd0, 9'd0, 9'd0, "mcb_cnt1");
        step(0, 0, 0, MULTI_OP, 9'd0, 9'd0, 9'd0, "mcb_release");
        idle("mcb_after");

        // Priority: branch beats load-use; reset abandons a flush sequence.
        step(0, 1, 0, LOAD_OP, 9'd5, 9'd0, 9'd5, "prio_br_lu");
        step(1, 0, 0, 5'd0, 9'd0, 9'd0, 9'd0, "rst_in_flush");
        idle("after_rst_flush");
        step(0, 1, 1, LOAD_OP, 9'd5, 9'd0, 9'd5, "busy_over_br");
        idle("busy_over_br_after");

        // Random traffic with small register numbers to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: exop = LOAD_OP;
                3:       exop = MULTI_OP;
                default: exop = 5'($urandom_range(0, 31));
            endcase
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0), exop,
                 9'($urandom_range(0, 3)), 9'($urandom_range(0, 3)),
                 9'($urandom_range(0, 3)), "rand");
        end

`ifdef HAZARD_STATS_EN
        // Long memory stall drives stall_cnt into saturation.
        for (int n = 0; n < 65540; n++) step(0, 0, 1, 5'd0, 9'd0, 9'd0, 9'd0, "stall_sat");
        checks++;
        assert (hif.stall_cnt === 16'hFFFF) else begin
            errors++;
            $error("FAIL stall_sat_final observed=%h expected=ffff", hif.stall_cnt);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
